// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set sequencer for the clock's BCD time counters.
// Produces wrapped BCD load values for the selected field, and a blink mask for it.
`default_nettype none

module time_set_ctrl #(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick_1s,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [23:0] time_in,
  output logic        hold,
  output logic        load,
  output logic [23:0] load_val,
  output logic [7:0]  blank_mask,
  output logic [1:0]  mode
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_S);

  state_t      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        blink_q, blink_d;
  logic        load_q, load_d;
  logic [23:0] load_val_q, load_val_d;
  logic        hold_q, hold_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  fld_cur, fld_max, fld_new;

  // Out-of-range or non-BCD input snaps to 00 (up) or the field maximum (down).
  function automatic logic [7:0] bcd_step(input logic [7:0] f, input logic [7:0] fmax,
                                          input logic up);
    logic [7:0] r;
    if (f[3:0] > 4'd9 || f > fmax) begin
      r = up ? 8'h00 : fmax;
    end else if (up) begin
      if (f == fmax)            r = 8'h00;
      else if (f[3:0] == 4'd9)  r = {f[7:4] + 4'd1, 4'd0};
      else                      r = {f[7:4], f[3:0] + 4'd1};
    end else begin
      if (f == 8'h00)           r = fmax;
      else if (f[3:0] == 4'd0)  r = {f[7:4] - 4'd1, 4'd9};
      else                      r = {f[7:4], f[3:0] - 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    fld_cur = time_in[7:0];
    fld_max = 8'h59;
    case (state_q)
      SET_HOUR: begin fld_cur = time_in[23:16]; fld_max = 8'h23; end
      SET_MIN:  fld_cur = time_in[15:8];
      default:  fld_cur = time_in[7:0];
    endcase
    fld_new = bcd_step(fld_cur, fld_max, btn_up);
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    blink_d    = blink_q;
    load_d     = 1'b0;
    load_val_d = load_val_q;
    if (btn_mode) begin
      state_d = state_t'(state_q + 2'd1);
      tmo_d   = 8'd0;
      blink_d = 1'b0;
    end else if (state_q != RUN) begin
      if (btn_up ^ btn_down) begin
        load_d  = 1'b1;
        tmo_d   = 8'd0;
        blink_d = 1'b0;
        case (state_q)
          SET_HOUR: load_val_d = {fld_new, time_in[15:0]};
          SET_MIN:  load_val_d = {time_in[23:16], fld_new, time_in[7:0]};
          default:  load_val_d = {time_in[23:8], fld_new};
        endcase
      end else if (tick_1s) begin
        if (tmo_q + 8'd1 == TMO_LIMIT) begin
          state_d = RUN;
          tmo_d   = 8'd0;
          blink_d = 1'b0;
        end else begin
          tmo_d   = tmo_q + 8'd1;
          blink_d = ~blink_q;
        end
      end
    end
    hold_d = (state_d != RUN);
    mask_d = 8'h00;
    if (blink_d) begin
      case (state_d)
        SET_HOUR: mask_d = 8'hC0;
        SET_MIN:  mask_d = 8'h18;
        SET_SEC:  mask_d = 8'h03;
        default:  mask_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      tmo_q      <= 8'd0;
      blink_q    <= 1'b0;
      load_q     <= 1'b0;
      load_val_q <= 24'd0;
      hold_q     <= 1'b0;
      mask_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      blink_q    <= blink_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      hold_q     <= hold_d;
      mask_q     <= mask_d;
    end
  end

  assign mode       = state_q;
  assign hold       = hold_q;
  assign load       = load_q;
  assign load_val   = load_val_q;
  assign blank_mask = mask_q;

endmodule

`default_nettype wire
